// File: rtl/candy_opfetch_if.sv
// Operand-fetch bus bundle: request side, register/SRAM read ports,
// writeback snoop, flush and the result handshake.
interface candy_opfetch_if #(
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 16,
    parameter int REG_AW  = 5
);
    logic               req_valid;
    logic               req_ready;
    logic               req_is_mem;
    logic [REG_AW-1:0]  req_reg_addr;
    logic [SRAM_AW-1:0] req_sram_addr;

    logic               reg_read_enable;
    logic [REG_AW-1:0]  reg_raddr;
    logic [DATA_W-1:0]  reg_rdata;

    logic               sram_read_enable;
    logic [SRAM_AW-1:0] sram_raddr;
    logic [DATA_W-1:0]  sram_rdata;

    logic               wb_reg_write_enable;
    logic [REG_AW-1:0]  wb_reg_waddr;
    logic [DATA_W-1:0]  wb_reg_wdata;

    logic               wb_sram_write_enable;
    logic [SRAM_AW-1:0] wb_sram_waddr;
    logic [DATA_W-1:0]  wb_sram_wdata;

    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;

    modport master (
        output req_valid, req_is_mem, req_reg_addr, req_sram_addr,
        input  req_ready,
        input  reg_read_enable, reg_raddr,
        output reg_rdata,
        input  sram_read_enable, sram_raddr,
        output sram_rdata,
        output wb_reg_write_enable, wb_reg_waddr, wb_reg_wdata,
        output wb_sram_write_enable, wb_sram_waddr, wb_sram_wdata,
        output flush,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  req_valid, req_is_mem, req_reg_addr, req_sram_addr,
        output req_ready,
        output reg_read_enable, reg_raddr,
        input  reg_rdata,
        output sram_read_enable, sram_raddr,
        input  sram_rdata,
        input  wb_reg_write_enable, wb_reg_waddr, wb_reg_wdata,
        input  wb_sram_write_enable, wb_sram_waddr, wb_sram_wdata,
        input  flush,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/candy_opfetch.sv
// Operand fetch: one register-file or SRAM read per request, with forwarding
// from writebacks that land while the read is in flight.
module candy_opfetch #(
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 16,
    parameter int REG_AW  = 5
) (
    input logic            clk_i,
    input logic            rst_ni,
    candy_opfetch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e             state_q,      state_d;
    logic               is_mem_q,     is_mem_d;
    logic [REG_AW-1:0]  reg_raddr_q,  reg_raddr_d;
    logic [SRAM_AW-1:0] sram_raddr_q, sram_raddr_d;
    logic               reg_ren_q,    reg_ren_d;
    logic               sram_ren_q,   sram_ren_d;
    logic               fwd_q,        fwd_d;
    logic [DATA_W-1:0]  fwd_data_q,   fwd_data_d;
    logic [DATA_W-1:0]  out_data_q,   out_data_d;

    logic              reg_hit;
    logic              sram_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rd_data;

    // The latched read address doubles as the forwarding match key.
    assign reg_hit  = !is_mem_q && bus.wb_reg_write_enable &&
                      (bus.wb_reg_waddr == reg_raddr_q);
    assign sram_hit = is_mem_q && bus.wb_sram_write_enable &&
                      (bus.wb_sram_waddr == sram_raddr_q);
    assign wb_hit   = reg_hit || sram_hit;
    assign wb_data  = is_mem_q ? bus.wb_sram_wdata : bus.wb_reg_wdata;
    assign rd_data  = is_mem_q ? bus.sram_rdata : bus.reg_rdata;

    always_comb begin
        state_d      = state_q;
        is_mem_d     = is_mem_q;
        reg_raddr_d  = reg_raddr_q;
        sram_raddr_d = sram_raddr_q;
        reg_ren_d    = 1'b0;
        sram_ren_d   = 1'b0;
        fwd_d        = fwd_q;
        fwd_data_d   = fwd_data_q;
        out_data_d   = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    is_mem_d = bus.req_is_mem;
                    if (bus.req_is_mem) begin
                        sram_raddr_d = bus.req_sram_addr;
                    end else begin
                        reg_raddr_d = bus.req_reg_addr;
                    end
                    reg_ren_d  = !bus.req_is_mem;
                    sram_ren_d = bus.req_is_mem;
                    fwd_d      = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wb_hit) begin
                    fwd_d      = 1'b1;
                    fwd_data_d = wb_data;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A writeback in this very cycle is the youngest value.
                if (wb_hit) begin
                    out_data_d = wb_data;
                end else if (fwd_q) begin
                    out_data_d = fwd_data_q;
                end else begin
                    out_data_d = rd_data;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            reg_ren_d  = 1'b0;
            sram_ren_d = 1'b0;
            fwd_d      = 1'b0;
            out_data_d = out_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            is_mem_q     <= 1'b0;
            reg_raddr_q  <= '0;
            sram_raddr_q <= '0;
            reg_ren_q    <= 1'b0;
            sram_ren_q   <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_data_q   <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            is_mem_q     <= is_mem_d;
            reg_raddr_q  <= reg_raddr_d;
            sram_raddr_q <= sram_raddr_d;
            reg_ren_q    <= reg_ren_d;
            sram_ren_q   <= sram_ren_d;
            fwd_q        <= fwd_d;
            fwd_data_q   <= fwd_data_d;
            out_data_q   <= out_data_d;
        end
    end

    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.out_valid        = (state_q == ST_HOLD);
    assign bus.out_data         = out_data_q;
    assign bus.reg_read_enable  = reg_ren_q;
    assign bus.reg_raddr        = reg_raddr_q;
    assign bus.sram_read_enable = sram_ren_q;
    assign bus.sram_raddr       = sram_raddr_q;

endmodule

// File: tb/tb_candy_opfetch.sv
// Directed self-checking bench for candy_opfetch: reads, backpressure,
// forwarding, flush and asynchronous reset.
module tb_candy_opfetch;

    logic clk;
    logic rst_ni;
    int   vectors;
    int   miscompares;

    candy_opfetch_if #(.DATA_W(32), .SRAM_AW(16), .REG_AW(5)) bus ();

    candy_opfetch #(.DATA_W(32), .SRAM_AW(16), .REG_AW(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic m,
                                 input logic [4:0] ra, input logic [15:0] sa);
        bus.req_valid     = v;
        bus.req_is_mem    = m;
        bus.req_reg_addr  = ra;
        bus.req_sram_addr = sa;
    endtask

    task automatic setRegWb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_reg_write_enable = we;
        bus.wb_reg_waddr        = a;
        bus.wb_reg_wdata        = d;
    endtask

    task automatic setSramWb(input logic we, input logic [15:0] a, input logic [31:0] d);
        bus.wb_sram_write_enable = we;
        bus.wb_sram_waddr        = a;
        bus.wb_sram_wdata        = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic releaseHold(input string tag);
        bus.out_ready = 1'b1;
        step(1);
        checkOutput({tag, "_ov_after_ready"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_ready_after_ready"}, 32'(bus.req_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        setRegWb(1'b0, 5'd0, 32'h0);
        setSramWb(1'b0, 16'h0, 32'h0);
        bus.reg_rdata  = 32'h0;
        bus.sram_rdata = 32'h0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state
        step(2);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", bus.out_data, 32'h0);
        checkOutput("rst_reg_ren", 32'(bus.reg_read_enable), 32'd0);
        checkOutput("rst_sram_ren", 32'(bus.sram_read_enable), 32'd0);
        rst_ni = 1'b1;
        step(1);

        // Register read of r5
        applyStimulus(1'b1, 1'b0, 5'd5, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkOutput("reg_issue_ren", 32'(bus.reg_read_enable), 32'd1);
        checkOutput("reg_issue_raddr", 32'(bus.reg_raddr), 32'd5);
        checkOutput("reg_issue_sram_ren", 32'(bus.sram_read_enable), 32'd0);
        checkOutput("reg_issue_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reg_issue_ov", 32'(bus.out_valid), 32'd0);
        bus.reg_rdata = 32'hDEADBEEF;
        step(1);
        checkOutput("reg_wait_ren", 32'(bus.reg_read_enable), 32'd0);
        checkOutput("reg_wait_ov", 32'(bus.out_valid), 32'd0);
        step(1);
        bus.reg_rdata = 32'h0;
        checkOutput("reg_hold_ov", 32'(bus.out_valid), 32'd1);
        checkOutput("reg_hold_data", bus.out_data, 32'hDEADBEEF);
        step(1);
        checkOutput("reg_hold2_data", bus.out_data, 32'hDEADBEEF);
        releaseHold("reg");

        // SRAM read with five cycles of backpressure; requests ignored in HOLD
        applyStimulus(1'b1, 1'b1, 5'd0, 16'h0040);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkOutput("sram_issue_ren", 32'(bus.sram_read_enable), 32'd1);
        checkOutput("sram_issue_raddr", 32'(bus.sram_raddr), 32'h40);
        checkOutput("sram_issue_reg_ren", 32'(bus.reg_read_enable), 32'd0);
        bus.sram_rdata = 32'h12345678;
        step(2);
        bus.sram_rdata = 32'h0;
        applyStimulus(1'b1, 1'b1, 5'd0, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_ov", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_data", bus.out_data, 32'h12345678);
            checkOutput("bp_raddr", 32'(bus.sram_raddr), 32'h40);
            bus.sram_rdata = 32'hFFFF0000 + 32'(i);
            step(1);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        releaseHold("bp");

        // Forward from a register writeback in WAIT
        applyStimulus(1'b1, 1'b0, 5'd3, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        bus.reg_rdata = 32'h0;
        step(1);
        setRegWb(1'b1, 5'd3, 32'hA5A5A5A5);
        step(1);
        setRegWb(1'b0, 5'd0, 32'h0);
        checkOutput("fwd_wait_data", bus.out_data, 32'hA5A5A5A5);
        releaseHold("fwd_wait");

        // Writeback to a different register is not forwarded
        applyStimulus(1'b1, 1'b0, 5'd3, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        step(1);
        setRegWb(1'b1, 5'd4, 32'hA5A5A5A5);
        step(1);
        setRegWb(1'b0, 5'd0, 32'h0);
        checkOutput("nofwd_addr_data", bus.out_data, 32'h0);
        releaseHold("nofwd_addr");

        // SRAM writeback to address 3 does not feed a register read
        applyStimulus(1'b1, 1'b0, 5'd3, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        setSramWb(1'b1, 16'h0003, 32'hA5A5A5A5);
        step(1);
        step(1);
        setSramWb(1'b0, 16'h0, 32'h0);
        checkOutput("nofwd_kind_data", bus.out_data, 32'h0);
        releaseHold("nofwd_kind");

        // Forward from ISSUE only, register read data ignored
        applyStimulus(1'b1, 1'b0, 5'd7, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        setRegWb(1'b1, 5'd7, 32'h11111111);
        step(1);
        setRegWb(1'b0, 5'd0, 32'h0);
        bus.reg_rdata = 32'h22222222;
        step(1);
        bus.reg_rdata = 32'h0;
        checkOutput("fwd_issue_data", bus.out_data, 32'h11111111);
        releaseHold("fwd_issue");

        // Two SRAM writebacks to 0x10: the later one wins
        applyStimulus(1'b1, 1'b1, 5'd0, 16'h0010);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        setSramWb(1'b1, 16'h0010, 32'h1);
        step(1);
        setSramWb(1'b1, 16'h0010, 32'h2);
        bus.sram_rdata = 32'h0;
        step(1);
        setSramWb(1'b0, 16'h0, 32'h0);
        checkOutput("dfwd_data", bus.out_data, 32'h2);
        releaseHold("dfwd");

        // Flush in WAIT, then a normal request
        applyStimulus(1'b1, 1'b0, 5'd9, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        step(1);
        bus.flush     = 1'b1;
        bus.reg_rdata = 32'h55555555;
        step(1);
        bus.flush = 1'b0;
        checkOutput("flush_wait_ov", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_wait_ready", 32'(bus.req_ready), 32'd1);
        step(2);
        checkOutput("flush_wait_ov_later", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_wait_data_kept", bus.out_data, 32'h2);
        applyStimulus(1'b1, 1'b0, 5'd9, 16'h0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        bus.reg_rdata = 32'h66666666;
        step(2);
        checkOutput("post_flush_ov", 32'(bus.out_valid), 32'd1);
        checkOutput("post_flush_data", bus.out_data, 32'h66666666);
        releaseHold("post_flush");

        // Flush in ISSUE drops the read enable
        applyStimulus(1'b1, 1'b1, 5'd0, 16'h0020);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        checkOutput("flush_issue_ren", 32'(bus.sram_read_enable), 32'd0);
        checkOutput("flush_issue_ready", 32'(bus.req_ready), 32'd1);

        // Asynchronous reset during ISSUE
        applyStimulus(1'b1, 1'b1, 5'd0, 16'h0030);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkOutput("arst_pre_ren", 32'(bus.sram_read_enable), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_sram_ren", 32'(bus.sram_read_enable), 32'd0);
        checkOutput("arst_sram_raddr", 32'(bus.sram_raddr), 32'd0);
        checkOutput("arst_reg_raddr", 32'(bus.reg_raddr), 32'd0);
        checkOutput("arst_ov", 32'(bus.out_valid), 32'd0);
        checkOutput("arst_data", bus.out_data, 32'h0);
        checkOutput("arst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        step(1);

        // Flush in IDLE is ignored; out_ready outside HOLD is ignored
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd1, 16'h0000);
        step(1);
        bus.flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000);
        checkOutput("idle_flush_ren", 32'(bus.reg_read_enable), 32'd1);
        checkOutput("idle_flush_raddr", 32'(bus.reg_raddr), 32'd1);
        bus.reg_rdata = 32'h0BADF00D;
        step(1);
        checkOutput("early_ready_ov", 32'(bus.out_valid), 32'd0);
        step(1);
        checkOutput("final_ov", 32'(bus.out_valid), 32'd1);
        checkOutput("final_data", bus.out_data, 32'h0BADF00D);
        step(1);
        checkOutput("final_ov_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("final_ready", 32'(bus.req_ready), 32'd1);
        bus.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
